elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller. Successor to the fixed 3-floor controller.
- Latches car and hall calls into pending registers and serves them with directional collective (SCAN) scheduling.
- Paces floor travel and door dwell with programmable cycle counters.
- Top-level block of the elevator subsystem; drives the car position, door and direction indicators.

Parameters:
- NUM_FLOORS, 4: floor count, at least 2. Floors are indexed 0..NUM_FLOORS-1, with 0 at the bottom.
- FLOOR_W, $clog2(NUM_FLOORS): width of the Floor output.
- MOVE_CYCLES, 2: cycles needed to travel one floor, at least 1.
- DOOR_CYCLES, 3: cycles the door stays open per stop, at least 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- CAR_REQ  in  NUM_FLOORS  in-car floor buttons. One bit per floor; a press is a one-cycle pulse or a level.
- HALL_UP  in  NUM_FLOORS  hall up buttons. Bit NUM_FLOORS-1 is ignored.
- HALL_DN  in  NUM_FLOORS  hall down buttons. Bit 0 is ignored.
- Open  out  1  door open.
- Floor  out  FLOOR_W  current floor index.
- Direction  out  2  2'b00 hold, 2'b10 up, 2'b01 down; 2'b11 is never driven.
- CAR_PEND  out  NUM_FLOORS  latched car calls.
- UP_PEND  out  NUM_FLOORS  latched hall-up calls.
- DN_PEND  out  NUM_FLOORS  latched hall-down calls.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST); all state updates on the CLK rising edge.
- Reset values: state IDLE, Floor=0, Open=0, Direction=2'b00, all PEND bits 0, counters 0.
  - RST overrides everything, including mid-move and mid-door.
  - No pending call survives reset.
- Request latching:
  - Each PEND bit is set by its input bit and cleared only when that call is served (below).
  - The ignored bits UP[top] and DN[0] never set.
- Effective request vector, used by all decisions: req = PEND | raw inputs.
  - A press is therefore acted on at the first edge after it.
- Derived terms, for current floor f:
  - above = any req bit at a floor > f.
  - below = any req bit at a floor < f.
  - here = CAR[f] | UP[f] | DN[f].
- IDLE (Direction=00, Open=0):
  - If here: enter DOOR (Open=1 at the next edge).
  - Else if above: enter MOVE with Direction=10 and load the move counter.
  - Else if below: enter MOVE with Direction=01.
  - above has priority over below on a tie.
- MOVE:
  - Counts MOVE_CYCLES cycles. On the expiry edge, Floor steps ±1 per Direction.
  - The stop decision on that same edge uses the new floor g. The car stops if:
    - CAR[g] is set; or
    - the hall call in the travel direction at g is set; or
    - no req exists beyond g in the travel direction.
  - Stop: enter DOOR, so Open=1 on the same edge Floor changes.
  - No stop: reload the counter and stay in MOVE.
  - Floor never leaves the range 0..NUM_FLOORS-1. At the top or bottom floor the no-req-beyond clause always forces a stop.
- DOOR:
  - Open=1 for DOOR_CYCLES cycles.
  - On entry, clear CAR_PEND[f] and the hall bit matching Direction.
  - If no req exists beyond f in Direction, or Direction=00: also clear the opposite hall bit at f, and set Direction=00 unless the reversal rule below applies at exit.
  - A press during DOOR of CAR_REQ[f], or of a hall bit at f that would be cleared, restarts the dwell counter. That bit is not latched.
- DOOR exit: Open=0 on the exit edge. Next state:
  - requests beyond in the old Direction: MOVE in the same direction;
  - else requests in the opposite direction: MOVE reversed;
  - else IDLE with Direction=00.
- A call set while its own floor is being passed in MOVE, outside the stop condition, is served on a later pass.
- Pending bits never clear without the door opening at that floor.

Test Plan:
All scenarios use NUM_FLOORS=4, MOVE_CYCLES=2, DOOR_CYCLES=3.
1. Local call: after RST, pulse CAR_REQ[0] at cycle t -> Open=1 for cycles t+1..t+3, Floor=0, Direction=00 throughout, CAR_PEND stays 0.
2. Travel: at idle on floor 0, pulse CAR_REQ[3] at t -> Direction=10 from t+1; Floor=1 at t+3, 2 at t+5, 3 at t+7; Open=1 for t+7..t+9; Direction=00 after door exit.
3. Collective: travelling up 0->3 for CAR_REQ[3], HALL_DN[2] and HALL_UP[1] pressed while Floor=0 -> stop at floor 1 (UP_PEND[1] cleared), pass floor 2, stop at 3, reverse Direction=01, stop at 2 (DN_PEND[2] cleared), then IDLE on floor 2.
4. Door extension: Open=1 at floor 2, CAR_REQ[2] pulsed in the second dwell cycle -> dwell restarts and Open stays 1 for three more cycles (five total); CAR_PEND[2] stays 0.
5. Reset mid-move: assert RST for one cycle while Floor=2 in MOVE with CAR_PEND[3]=1 -> next edge Floor=0, Open=0, Direction=00, all PEND=0; the car stays idle afterwards.
6. Ignored buttons: pulse HALL_UP[3] and HALL_DN[0] from idle -> all PEND bits stay 0, no movement, Open stays 0.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches car/hall calls and serves them with
// directional collective (SCAN) scheduling, pacing travel and door dwell by counters.
`timescale 1ns/1ps
module elevator_ctrl_n #(
   parameter int NUM_FLOORS  = 4,
   parameter int FLOOR_W     = $clog2(NUM_FLOORS),
   parameter int MOVE_CYCLES = 2,
   parameter int DOOR_CYCLES = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NUM_FLOORS-1:0] CAR_REQ,
   input  logic [NUM_FLOORS-1:0] HALL_UP,
   input  logic [NUM_FLOORS-1:0] HALL_DN,
   output logic                  Open,
   output logic [FLOOR_W-1:0]    Floor,
   output logic [1:0]            Direction,
   output logic [NUM_FLOORS-1:0] CAR_PEND,
   output logic [NUM_FLOORS-1:0] UP_PEND,
   output logic [NUM_FLOORS-1:0] DN_PEND
);

   localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MOVE = 2'd1;
   localparam logic [1:0] ST_DOOR = 2'd2;

   localparam logic [1:0] DIR_HOLD = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b10;
   localparam logic [1:0] DIR_DN   = 2'b01;

   // No up call exists at the top floor and no down call at the bottom floor.
   localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

   logic [1:0]            state_q, state_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d;
   logic [1:0]            dir_q, dir_d;
   logic [1:0]            travel_dir_q, travel_dir_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_FLOORS-1:0] car_pend_q, car_pend_d;
   logic [NUM_FLOORS-1:0] up_pend_q, up_pend_d;
   logic [NUM_FLOORS-1:0] dn_pend_q, dn_pend_d;

   logic [NUM_FLOORS-1:0] up_in, dn_in;
   logic [NUM_FLOORS-1:0] car_req, up_req, dn_req, any_req;
   logic [NUM_FLOORS-1:0] above_f, below_f, above_g, below_g, oh_f, oh_g;
   logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
   logic [FLOOR_W-1:0]    floor_g;
   logic                  here_f, req_above_f, req_below_f, req_above_g, req_below_g;
   logic                  car_g, up_g, dn_g, going_up, beyond_g, stop_g;
   logic                  clr_up_ok, clr_dn_ok, door_press, go_up, go_dn;

   assign up_in   = HALL_UP & UP_MASK;
   assign dn_in   = HALL_DN & DN_MASK;
   assign car_req = car_pend_q | CAR_REQ;
   assign up_req  = up_pend_q | up_in;
   assign dn_req  = dn_pend_q | dn_in;
   assign any_req = car_req | up_req | dn_req;

   // Floor reached at the end of the current move step.
   assign going_up = (dir_q == DIR_UP);
   assign floor_g  = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_masks
         assign above_f[gi] = (gi > int'(floor_q));
         assign below_f[gi] = (gi < int'(floor_q));
         assign oh_f[gi]    = (gi == int'(floor_q));
         assign above_g[gi] = (gi > int'(floor_g));
         assign below_g[gi] = (gi < int'(floor_g));
         assign oh_g[gi]    = (gi == int'(floor_g));
      end
   endgenerate

   assign here_f      = |(any_req & oh_f);
   assign req_above_f = |(any_req & above_f);
   assign req_below_f = |(any_req & below_f);
   assign req_above_g = |(any_req & above_g);
   assign req_below_g = |(any_req & below_g);
   assign car_g       = |(car_req & oh_g);
   assign up_g        = |(up_req & oh_g);
   assign dn_g        = |(dn_req & oh_g);
   assign beyond_g    = going_up ? req_above_g : req_below_g;
   assign stop_g      = car_g | (going_up ? up_g : dn_g) | ~beyond_g;

   // While the door is open, hall calls matching the shown direction are absorbed.
   assign clr_up_ok  = (dir_q != DIR_DN);
   assign clr_dn_ok  = (dir_q != DIR_UP);
   assign door_press = |((CAR_REQ & oh_f)
                       | (up_in & oh_f & {NUM_FLOORS{clr_up_ok}})
                       | (dn_in & oh_f & {NUM_FLOORS{clr_dn_ok}}));

   assign go_up = (travel_dir_q == DIR_DN) ? (~req_below_f & req_above_f) : req_above_f;
   assign go_dn = (travel_dir_q == DIR_DN) ? req_below_f : (~req_above_f & req_below_f);

   always_comb begin
      state_d      = state_q;
      floor_d      = floor_q;
      dir_d        = dir_q;
      travel_dir_d = travel_dir_q;
      cnt_d        = cnt_q;
      clr_car      = '0;
      clr_up       = '0;
      clr_dn       = '0;
      case (state_q)
         ST_IDLE: begin
            if (here_f) begin
               state_d      = ST_DOOR;
               cnt_d        = DOOR_LOAD;
               dir_d        = DIR_HOLD;
               travel_dir_d = DIR_HOLD;
               clr_car      = oh_f;
               clr_up       = oh_f;
               clr_dn       = oh_f;
            end else if (req_above_f) begin
               state_d      = ST_MOVE;
               cnt_d        = MOVE_LOAD;
               dir_d        = DIR_UP;
               travel_dir_d = DIR_UP;
            end else if (req_below_f) begin
               state_d      = ST_MOVE;
               cnt_d        = MOVE_LOAD;
               dir_d        = DIR_DN;
               travel_dir_d = DIR_DN;
            end
         end
         ST_MOVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               floor_d = floor_g;
               if (stop_g) begin
                  state_d      = ST_DOOR;
                  cnt_d        = DOOR_LOAD;
                  travel_dir_d = dir_q;
                  clr_car      = oh_g;
                  if (going_up) clr_up = oh_g;
                  else          clr_dn = oh_g;
                  if (!beyond_g) begin
                     clr_up = oh_g;
                     clr_dn = oh_g;
                     dir_d  = DIR_HOLD;
                  end
               end else begin
                  cnt_d = MOVE_LOAD;
               end
            end
         end
         ST_DOOR: begin
            clr_car = oh_f;
            if (clr_up_ok) clr_up = oh_f;
            if (clr_dn_ok) clr_dn = oh_f;
            if (door_press) begin
               cnt_d = DOOR_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (go_up) begin
               state_d      = ST_MOVE;
               cnt_d        = MOVE_LOAD;
               dir_d        = DIR_UP;
               travel_dir_d = DIR_UP;
            end else if (go_dn) begin
               state_d      = ST_MOVE;
               cnt_d        = MOVE_LOAD;
               dir_d        = DIR_DN;
               travel_dir_d = DIR_DN;
            end else begin
               state_d      = ST_IDLE;
               dir_d        = DIR_HOLD;
               travel_dir_d = DIR_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dir_d   = DIR_HOLD;
         end
      endcase
      // Clearing wins over a same-cycle press so a served call never re-latches.
      car_pend_d = (car_pend_q | CAR_REQ) & ~clr_car;
      up_pend_d  = (up_pend_q | up_in) & ~clr_up;
      dn_pend_d  = (dn_pend_q | dn_in) & ~clr_dn;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         floor_q      <= '0;
         dir_q        <= DIR_HOLD;
         travel_dir_q <= DIR_HOLD;
         cnt_q        <= '0;
         car_pend_q   <= '0;
         up_pend_q    <= '0;
         dn_pend_q    <= '0;
      end else begin
         state_q      <= state_d;
         floor_q      <= floor_d;
         dir_q        <= dir_d;
         travel_dir_q <= travel_dir_d;
         cnt_q        <= cnt_d;
         car_pend_q   <= car_pend_d;
         up_pend_q    <= up_pend_d;
         dn_pend_q    <= dn_pend_d;
      end
   end

   assign Open      = (state_q == ST_DOOR);
   assign Floor     = floor_q;
   assign Direction = dir_q;
   assign CAR_PEND  = car_pend_q;
   assign UP_PEND   = up_pend_q;
   assign DN_PEND   = dn_pend_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Self-checking bench for elevator_ctrl_n (4 floors, 2-cycle moves, 3-cycle dwell):
// per-cycle vector table plus hand-written door-extension and reset-mid-move sequences.
`timescale 1ns/1ps
module tb_elevator_ctrl_n;

   logic       clk;
   logic       rst;
   logic [3:0] car_req, hall_up, hall_dn;
   logic       open_o;
   logic [1:0] floor_o;
   logic [1:0] dir_o;
   logic [3:0] car_pend, up_pend, dn_pend;

   elevator_ctrl_n #(
      .NUM_FLOORS (4),
      .FLOOR_W    (2),
      .MOVE_CYCLES(2),
      .DOOR_CYCLES(3)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .CAR_REQ  (car_req),
      .HALL_UP  (hall_up),
      .HALL_DN  (hall_dn),
      .Open     (open_o),
      .Floor    (floor_o),
      .Direction(dir_o),
      .CAR_PEND (car_pend),
      .UP_PEND  (up_pend),
      .DN_PEND  (dn_pend)
   );

   typedef struct packed {
      logic       open;
      logic [1:0] floor;
      logic [1:0] dir;
      logic [3:0] cp;
      logic [3:0] upp;
      logic [3:0] dnp;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic [3:0] car;
      logic [3:0] up;
      logic [3:0] dn;
      exp_t       e;
   } vec_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   tag    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic add(input logic r, input logic [3:0] car, input logic [3:0] up,
                      input logic [3:0] dn, input logic op, input logic [1:0] fl,
                      input logic [1:0] dr, input logic [3:0] cp, input logic [3:0] upp,
                      input logic [3:0] dnp);
      vec_t v;
      v.rst = r; v.car = car; v.up = up; v.dn = dn;
      v.e   = '{open: op, floor: fl, dir: dr, cp: cp, upp: upp, dnp: dnp};
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, queue the expected outputs after the next edge, then compare.
   task automatic step(input vec_t v);
      exp_t e, a;
      rst = v.rst; car_req = v.car; hall_up = v.up; hall_dn = v.dn;
      sb_q.push_back(v.e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      a = {open_o, floor_o, dir_o, car_pend, up_pend, dn_pend};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL vec%0d: got open=%b floor=%0d dir=%b car=%b up=%b dn=%b, want open=%b floor=%0d dir=%b car=%b up=%b dn=%b",
                  tag, a.open, a.floor, a.dir, a.cp, a.upp, a.dnp,
                  e.open, e.floor, e.dir, e.cp, e.upp, e.dnp);
      end else begin
         $display("pass vec%0d: open=%b floor=%0d dir=%b car=%b up=%b dn=%b",
                  tag, a.open, a.floor, a.dir, a.cp, a.upp, a.dnp);
      end
      tag++;
   endtask

   task automatic run1(input logic r, input logic [3:0] car, input logic [3:0] up,
                       input logic [3:0] dn, input logic op, input logic [1:0] fl,
                       input logic [1:0] dr, input logic [3:0] cp, input logic [3:0] upp,
                       input logic [3:0] dnp);
      vec_t v;
      v.rst = r; v.car = car; v.up = up; v.dn = dn;
      v.e   = '{open: op, floor: fl, dir: dr, cp: cp, upp: upp, dnp: dnp};
      step(v);
   endtask

   initial begin
      rst = 1'b1; car_req = '0; hall_up = '0; hall_dn = '0;

      // reset state
      add(1, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      add(1, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      // local call at floor 0
      add(0, 4'b0001, 4'h0, 4'h0, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      // ignored buttons: top up and bottom down
      add(0, 4'h0, 4'b1000, 4'b0001, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) add(0, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      // travel 0 -> 3
      add(0, 4'b1000, 4'h0, 4'h0, 0, 0, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 0, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 1, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 1, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 2, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 2, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 3, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 3, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 3, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 3, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 3, 2'b00, 4'h0, 4'h0, 4'h0);
      add(1, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);
      // collective: up to 3 with stop at 1, then down to 2
      add(0, 4'b1000, 4'h0, 4'h0, 0, 0, 2'b10, 4'b1000, 4'h0, 4'h0);
      add(0, 4'h0, 4'b0010, 4'b0100, 0, 0, 2'b10, 4'b1000, 4'b0010, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 1, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 0, 1, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 0, 1, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 0, 2, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 0, 2, 2'b10, 4'b1000, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 3, 2'b00, 4'h0, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 3, 2'b00, 4'h0, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 3, 2'b00, 4'h0, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 0, 3, 2'b01, 4'h0, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 0, 3, 2'b01, 4'h0, 4'h0, 4'b0100);
      add(0, 4'h0, 4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      add(0, 4'h0, 4'h0, 4'h0, 0, 2, 2'b00, 4'h0, 4'h0, 4'h0);

      foreach (vecs[i]) step(vecs[i]);

      // door extension at floor 2: re-press in the second dwell cycle gives five open cycles
      run1(0, 4'b0100, 4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      run1(0, 4'b0100, 4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 1, 2, 2'b00, 4'h0, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 0, 2, 2'b00, 4'h0, 4'h0, 4'h0);

      // reset mid-move at floor 2 with a pending car call to 3
      run1(1, 4'h0,    4'h0, 4'h0, 0, 0, 2'b00, 4'h0,    4'h0, 4'h0);
      run1(0, 4'b1000, 4'h0, 4'h0, 0, 0, 2'b10, 4'b1000, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 0, 0, 2'b10, 4'b1000, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 0, 1, 2'b10, 4'b1000, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 0, 1, 2'b10, 4'b1000, 4'h0, 4'h0);
      run1(0, 4'h0,    4'h0, 4'h0, 0, 2, 2'b10, 4'b1000, 4'h0, 4'h0);
      run1(1, 4'h0,    4'h0, 4'h0, 0, 0, 2'b00, 4'h0,    4'h0, 4'h0);
      for (int i = 0; i < 6; i++)
         run1(0, 4'h0, 4'h0, 4'h0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
